// File: rtl/rast_pkg.sv
// Shared rasterizer types: coordinate/pixel typedefs, projection FSM states and the
// projection latency constant for the default divider width.
package rast_pkg;

  typedef logic signed [15:0] coord_t;
  typedef logic        [15:0] pix_t;

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, CHECK, OUT, DROP} proj_state_t;

  localparam int unsigned DIV_W_DEF = 32;
  localparam int unsigned PROJ_LAT  = 2 * DIV_W_DEF + 2;

  function automatic logic [31:0] abs32(logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is produced on the
// start edge itself, so done pulses the cycle after NUM_W edges of work.
module seq_divider import rast_pkg::*; #(
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o
);

  localparam int unsigned CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, rem_d, rem_in, den_q, den_d, den_cur, diff;
  logic [NUM_W-1:0] quo_q, quo_d, quo_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DEN_W:0]   shifted;
  logic             ge;

  always_comb begin
    rem_in  = start_i ? '0 : rem_q;
    quo_in  = start_i ? num_i : quo_q;
    den_cur = start_i ? den_i : den_q;
    shifted = {rem_in, quo_in[NUM_W-1]};
    ge      = shifted >= {1'b0, den_cur};
    // Remainder stays below the divisor, so the low DEN_W bits of the difference suffice.
    diff    = shifted[DEN_W-1:0] - den_cur;

    rem_d  = rem_q;
    quo_d  = quo_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (start_i || busy_q) begin
      den_d  = den_cur;
      rem_d  = ge ? diff : shifted[DEN_W-1:0];
      quo_d  = {quo_in[NUM_W-2:0], ge};
      cnt_d  = start_i ? CW'(NUM_W - 1) : cnt_q - 1'b1;
      busy_d = (cnt_d != '0);
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/vertex_project.sv
// Perspective projection of one camera-space vertex to a clipped screen pixel.
// Define VERTEX_PROJECT_ROUND_EN to round quotients half away from zero instead of truncating.
module vertex_project import rast_pkg::*; #(
  parameter int unsigned FOCAL = 128,
  parameter int unsigned DIV_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vert_valid,
  output logic        vert_ready,
  input  coord_t      vx,
  input  coord_t      vy,
  input  coord_t      vz,
  input  pix_t        width,
  input  pix_t        height,
  output pix_t        pixelX,
  output pix_t        pixelY,
  output logic        valid,
  input  logic        ready,
  output logic [15:0] drop_count,
  output logic [15:0] pix_count
);

  localparam int unsigned SW = DIV_W + 2;

  proj_state_t state_q, state_d;

  logic                    have_q, have_d;
  coord_t                  vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  pix_t                    width_q, width_d, height_q, height_d;
  logic signed [DIV_W:0]   qx_q, qx_d, qy_q, qy_d;
  pix_t                    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                    valid_q, valid_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d, pix_cnt_q, pix_cnt_d;

  logic                    acc, vz_pos, in_bounds;
  logic signed [31:0]      prod_x, prod_y;
  logic [DIV_W-1:0]        rnd, num_x, num_y, div_num, div_quo;
  logic                    div_start, div_busy, div_done, q_neg;
  logic [DIV_W:0]          q_mag, q_signed;
  logic [SW-1:0]           sx, sy;

  always_comb begin
    prod_x = 32'(vx_q) * 32'(FOCAL);
    prod_y = 32'(vy_q) * 32'(FOCAL);
`ifdef VERTEX_PROJECT_ROUND_EN
    rnd = DIV_W'({1'b0, vz_q[14:1]});
`else
    rnd = '0;
`endif
    num_x = DIV_W'(abs32(prod_x)) + rnd;
    num_y = DIV_W'(abs32(prod_y)) + rnd;
  end

  seq_divider #(
    .NUM_W (DIV_W),
    .DEN_W (16)
  ) u_div (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (vz_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  assign acc    = vert_valid && vert_ready;
  assign vz_pos = !vz_q[15] && (vz_q != '0);

  // Screen-space coordinates and clip test; width/height of 0 reject everything.
  always_comb begin
    sx = SW'(qx_q) + SW'({1'b0, width_q[15:1]});
    sy = SW'({1'b0, height_q[15:1]}) - SW'(qy_q);
    in_bounds = !sx[SW-1] && (sx < SW'(width_q)) && !sy[SW-1] && (sy < SW'(height_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (have_q) state_d = vz_pos ? DIV_X : DROP;
      DIV_X:   if (div_done) state_d = DIV_Y;
      DIV_Y:   if (div_done) state_d = CHECK;
      CHECK:   state_d = in_bounds ? OUT : DROP;
      OUT:     if (ready) state_d = IDLE;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vert_ready = !reset && (state_q == IDLE) && !have_q;
    // The x quotient is read on the same edge that launches the y division.
    div_start  = !div_busy && (((state_q == IDLE) && have_q && vz_pos) ||
                               ((state_q == DIV_X) && div_done));
    div_num    = (state_q == IDLE) ? num_x : num_y;
    pixelX     = pix_x_q;
    pixelY     = pix_y_q;
    valid      = valid_q;
    drop_count = drop_cnt_q;
    pix_count  = pix_cnt_q;
  end

  always_comb begin
    have_d     = acc;
    vx_d       = acc ? vx : vx_q;
    vy_d       = acc ? vy : vy_q;
    vz_d       = acc ? vz : vz_q;
    width_d    = acc ? width : width_q;
    height_d   = acc ? height : height_q;

    q_neg      = (state_q == DIV_X) ? vx_q[15] : vy_q[15];
    q_mag      = {1'b0, div_quo};
    q_signed   = q_neg ? -q_mag : q_mag;
    qx_d       = ((state_q == DIV_X) && div_done) ? $signed(q_signed) : qx_q;
    qy_d       = ((state_q == DIV_Y) && div_done) ? $signed(q_signed) : qy_q;

    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    valid_d    = valid_q;
    drop_cnt_d = drop_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    if ((state_q == CHECK) && in_bounds) begin
      pix_x_d = sx[15:0];
      pix_y_d = sy[15:0];
      valid_d = 1'b1;
    end
    if ((state_q == OUT) && ready) begin
      valid_d = 1'b0;
      if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
    end
    if ((state_q == DROP) && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_q     <= 1'b0;
      vx_q       <= '0;
      vy_q       <= '0;
      vz_q       <= '0;
      width_q    <= '0;
      height_q   <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      valid_q    <= 1'b0;
      drop_cnt_q <= '0;
      pix_cnt_q  <= '0;
    end else begin
      have_q     <= have_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vz_q       <= vz_d;
      width_q    <= width_d;
      height_q   <= height_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
    end
  end

endmodule

// File: tb/tb_vertex_project.sv
// Directed bench for vertex_project: expected pixels go through a scoreboard queue that a
// monitor drains on each handshake; counters, latency and stall behaviour are checked inline.
module tb_vertex_project;
  import rast_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        vert_valid;
  logic        vert_ready;
  coord_t      vx, vy, vz;
  pix_t        width, height;
  pix_t        pixelX, pixelY;
  logic        valid;
  logic        ready;
  logic [15:0] drop_count, pix_count;

  vertex_project dut (
    .clk        (clk),
    .reset      (reset),
    .vert_valid (vert_valid),
    .vert_ready (vert_ready),
    .vx         (vx),
    .vy         (vy),
    .vz         (vz),
    .width      (width),
    .height     (height),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .valid      (valid),
    .ready      (ready),
    .drop_count (drop_count),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

`ifdef VERTEX_PROJECT_ROUND_EN
  localparam int X_ONE_THIRD = 171;
`else
  localparam int X_ONE_THIRD = 170;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: each handshake pops one expected {pixelX, pixelY}.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pixel: got %0d,%0d, expected no output", pixelX, pixelY);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel_xy", {pixelX, pixelY}, mon_exp);
      end
    end
  end

  task automatic send(input int x, input int y, input int z);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = vert_ready;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: vert_ready=0, expected 1");
      return;
    end
    vx = 16'(x);
    vy = 16'(y);
    vz = 16'(z);
    vert_valid = 1'b1;
    @(posedge clk);
    #1 vert_valid = 1'b0;
  endtask

  // Pushes the expected pixel and measures edges from accept to valid.
  task automatic wait_pix(input string name, input int ex, input int ey);
    int n = 0;
    exp_q.push_back({16'(ex), 16'(ey)});
    while (!valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check({name, "_latency"}, n, PROJ_LAT);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1 got = vert_ready;
    end
    check("idle_timeout", got, 1);
  endtask

  task automatic drop_z(input int z, input int exp_drops);
    send(5, 5, z);
    check("drop_ready_e0", vert_ready, 0);
    @(posedge clk);
    #1 check("drop_ready_e1", vert_ready, 0);
    @(posedge clk);
    #1 check("drop_ready_e2", vert_ready, 1);
    check("drop_count", drop_count, exp_drops);
  endtask

  initial begin
    reset = 1'b1;
    vert_valid = 1'b0;
    ready = 1'b1;
    vx = '0;
    vy = '0;
    vz = '0;
    width = 16'd256;
    height = 16'd256;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vert_ready", vert_ready, 0);
    check("rst_valid", valid, 0);
    check("rst_pixel", {pixelX, pixelY}, 0);
    check("rst_counts", {drop_count, pix_count}, 0);
    @(negedge clk) reset = 1'b0;
    #1 check("idle_vert_ready", vert_ready, 1);

    send(10, 20, 64);
    wait_pix("v10_20_64", 148, 88);
    @(posedge clk);
    #1 check("valid_drops", valid, 0);
    check("pix_count_1", pix_count, 1);

    // Screen size is sampled on accept; changing it afterwards must not matter.
    send(-3, 3, 4);
    width = 16'd0;
    height = 16'd0;
    wait_pix("vm3_3_4", 32, 32);
    width = 16'd256;
    height = 16'd256;
    send(1, 0, 3);
    wait_pix("v1_0_3", X_ONE_THIRD, 128);
    @(posedge clk);
    #1 check("pix_count_3", pix_count, 3);

    drop_z(0, 1);
    drop_z(-5, 2);
    send(-10, 5, 3);
    wait_idle();
    check("left_clip_drop", drop_count, 3);
    check("left_clip_pix", pix_count, 3);

    ready = 1'b0;
    send(10, 20, 64);
    wait_pix("hold", 148, 88);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", valid, 1);
      check("hold_pixel", {pixelX, pixelY}, {16'd148, 16'd88});
      check("hold_vert_ready", vert_ready, 0);
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", valid, 0);
    check("hold_release_ready", vert_ready, 1);
    check("hold_pix_count", pix_count, 4);

    send(10, 20, 64);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_counts", {drop_count, pix_count}, 0);
    check("midrst_vert_ready", vert_ready, 0);
    @(negedge clk) reset = 1'b0;
    send(10, 20, 64);
    wait_pix("post_reset", 148, 88);
    @(posedge clk);
    #1 check("post_reset_pix", pix_count, 1);

    width = 16'd0;
    send(10, 20, 64);
    width = 16'd256;
    wait_idle();
    check("zero_width_drop", drop_count, 1);
    check("zero_width_pix", pix_count, 1);

    @(negedge clk) force dut.drop_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1 release dut.drop_cnt_q;
    check("preload", drop_count, 16'hFFFD);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 0);
      wait_idle();
      check("saturate", drop_count, (i == 0) ? 16'hFFFE : 16'hFFFF);
    end

    repeat (5) @(posedge clk);
    #1 check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
